// File: rtl/mem_pkg.sv
// Shared constants for the MOV/MFC memory: data types, direction, FSM encoding.
package mem_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // dtype 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] dt_norm(input logic [1:0] dt);
    return (dt == 2'b11) ? DT_WORD : dt;
  endfunction

endpackage

// File: rtl/mem_mfc_ram_if.sv
// MOV/MFC bus between the microprogrammed control unit (master) and memory (slave).
// Optional macro MISALIGN_FAULT_EN adds the fault return signal.
interface mem_mfc_ram_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mov;
  logic              rw;
  logic [1:0]        dtype;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              busy;
`ifdef MISALIGN_FAULT_EN
  logic              fault;
`endif

`ifdef MISALIGN_FAULT_EN
  modport master (output mov, rw, dtype, addr, data_in, input data_out, mfc, busy, fault);
  modport slave  (input mov, rw, dtype, addr, data_in, output data_out, mfc, busy, fault);
`else
  modport master (output mov, rw, dtype, addr, data_in, input data_out, mfc, busy);
  modport slave  (input mov, rw, dtype, addr, data_in, output data_out, mfc, busy);
`endif

endinterface

// File: rtl/mem_latency_cnt.sv
// 4-bit down-counter used to model the fixed memory access latency.
module mem_latency_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_count;

  // Load takes priority over decrement; async clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_mfc_ram.sv
// Byte-addressable big-endian memory with MOV/MFC handshake and fixed latency.
// Optional macro MISALIGN_FAULT_EN: misaligned accesses fault instead of being aligned.
module mem_mfc_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_mfc_ram_if.slave  bus
);

  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  logic [1:0]        r_state;
  logic              r_rw;
  logic [1:0]        r_dtype;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_dout;
  logic              r_mfc;
  logic [7:0]        r_mem [2**ADDR_W];

  logic [1:0]        w_dt;
  logic [ADDR_W-1:0] w_a0;
  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;
  logic              w_fault;
  logic              w_zero;
  logic              w_load;
  logic              w_fire;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [31:0]       w_rdata;

  assign w_dt   = dt_norm(r_dtype);
  assign w_load = (r_state == ST_IDLE) && bus.mov;
  assign w_fire = (r_state == ST_WAIT) && w_zero;

  mem_latency_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_en       ((r_state == ST_WAIT) && !w_zero),
    .o_zero     (w_zero)
  );

`ifdef MISALIGN_FAULT_EN
  logic r_fault;
  logic w_misaligned;

  assign w_misaligned = ((w_dt == DT_HALF) && r_addr[0]) ||
                        ((w_dt == DT_WORD) && (r_addr[1:0] != 2'b00));
  assign w_fault      = w_misaligned;
  assign w_a0         = r_addr;
  assign bus.fault    = r_fault;
`else
  assign w_fault = 1'b0;

  // Force natural alignment by clearing the low address bits.
  always_comb begin
    w_a0 = r_addr;
    if (w_dt == DT_HALF) begin
      w_a0[0] = 1'b0;
    end else if (w_dt == DT_WORD) begin
      w_a0[1:0] = 2'b00;
    end
  end
`endif

  // Offsets wrap modulo the memory size through natural truncation.
  assign w_a1 = w_a0 + ADDR_W'(1);
  assign w_a2 = w_a0 + ADDR_W'(2);
  assign w_a3 = w_a0 + ADDR_W'(3);

  assign w_wr_en = w_fire && (r_rw == RW_WRITE) && !w_fault;
  assign w_rd_en = w_fire && (r_rw == RW_READ) && !w_fault;

  // Big-endian read pack: lowest address lands in the most significant used byte.
  always_comb begin
    w_rdata = 32'd0;
    case (w_dt)
      DT_BYTE: w_rdata = {24'd0, r_mem[w_a0]};
      DT_HALF: w_rdata = {16'd0, r_mem[w_a0], r_mem[w_a1]};
      default: w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    endcase
  end

  // Array write on the completion edge; array has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      case (w_dt)
        DT_BYTE: begin
          r_mem[w_a0] <= r_din[7:0];
        end
        DT_HALF: begin
          r_mem[w_a0] <= r_din[15:8];
          r_mem[w_a1] <= r_din[7:0];
        end
        default: begin
          r_mem[w_a0] <= r_din[31:24];
          r_mem[w_a1] <= r_din[23:16];
          r_mem[w_a2] <= r_din[15:8];
          r_mem[w_a3] <= r_din[7:0];
        end
      endcase
    end
  end

  // Handshake FSM: latch request, wait out latency, hold mfc until mov drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rw    <= RW_READ;
      r_dtype <= DT_BYTE;
      r_addr  <= '0;
      r_din   <= 32'd0;
      r_dout  <= 32'd0;
      r_mfc   <= 1'b0;
`ifdef MISALIGN_FAULT_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mov) begin
            r_rw    <= bus.rw;
            r_dtype <= bus.dtype;
            r_addr  <= bus.addr;
            r_din   <= bus.data_in;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_zero) begin
            r_mfc <= 1'b1;
`ifdef MISALIGN_FAULT_EN
            r_fault <= w_fault;
`endif
            if (w_rd_en) begin
              r_dout <= w_rdata;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!bus.mov) begin
            r_mfc <= 1'b0;
`ifdef MISALIGN_FAULT_EN
            r_fault <= 1'b0;
`endif
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = r_dout;
  assign bus.mfc      = r_mfc;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
